// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the dual-master Wishbone arbiter.
package wb_arb_pkg;

  // Arbiter grant state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Outstanding-transfer counter must hold 0..max_out inclusive
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wb_dual_arbiter.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter with registered grant and a
// per-grant outstanding-transfer limit. m1 (data side) has fixed priority over m0.
// Optional macro WB_DUAL_ARBITER_RR_EN: on simultaneous requests in IDLE, grant the
// master that was not granted most recently instead of fixed priority.
module wb_dual_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADR_WIDTH       = 32,
  parameter int unsigned DAT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // m0: instruction-side master
  input  logic                   m0_wb_cyc_i,
  input  logic                   m0_wb_stb_i,
  input  logic                   m0_wb_we_i,
  input  logic [DAT_WIDTH/8-1:0] m0_wb_sel_i,
  input  logic [ADR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_wb_wdat_i,
  output logic [DAT_WIDTH-1:0]   m0_wb_rdat_o,
  output logic                   m0_wb_ack_o,
  output logic                   m0_wb_err_o,
  output logic                   m0_wb_stall_o,
  // m1: data-side master
  input  logic                   m1_wb_cyc_i,
  input  logic                   m1_wb_stb_i,
  input  logic                   m1_wb_we_i,
  input  logic [DAT_WIDTH/8-1:0] m1_wb_sel_i,
  input  logic [ADR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_wb_wdat_i,
  output logic [DAT_WIDTH-1:0]   m1_wb_rdat_o,
  output logic                   m1_wb_ack_o,
  output logic                   m1_wb_err_o,
  output logic                   m1_wb_stall_o,
  // shared downstream bus
  output logic                   s_wb_cyc_o,
  output logic                   s_wb_stb_o,
  output logic                   s_wb_we_o,
  output logic [DAT_WIDTH/8-1:0] s_wb_sel_o,
  output logic [ADR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DAT_WIDTH-1:0]   s_wb_wdat_o,
  input  logic [DAT_WIDTH-1:0]   s_wb_rdat_i,
  input  logic                   s_wb_ack_i,
  input  logic                   s_wb_err_i,
  input  logic                   s_wb_stall_i
);

  localparam int unsigned    CntW   = cnt_width(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  arb_en_q;

  logic                  own_cyc, own_stb, own_we;
  logic [DAT_WIDTH/8-1:0] own_sel;
  logic [ADR_WIDTH-1:0]  own_adr;
  logic [DAT_WIDTH-1:0]  own_wdat;
  logic                  full, rsp_valid, accept;

`ifdef WB_DUAL_ARBITER_RR_EN
  // 1 means m0 was granted most recently; reset value 0 lets m0 win first contention
  logic                  last_m0_q, last_m0_d;
`endif

  assign full      = (cnt_q == CntMax);
  // Responses with nothing outstanding are stale (e.g. after an abort) and dropped
  assign rsp_valid = (s_wb_ack_i | s_wb_err_i) & (cnt_q != '0);
  assign accept    = s_wb_stb_o & ~s_wb_stall_i;

  // Select the current owner's request signals; all zero in IDLE
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_sel  = '0;
    own_adr  = '0;
    own_wdat = '0;
    case (state_q)
      GNT0: begin
        own_cyc  = m0_wb_cyc_i;
        own_stb  = m0_wb_stb_i;
        own_we   = m0_wb_we_i;
        own_sel  = m0_wb_sel_i;
        own_adr  = m0_wb_adr_i;
        own_wdat = m0_wb_wdat_i;
      end
      GNT1: begin
        own_cyc  = m1_wb_cyc_i;
        own_stb  = m1_wb_stb_i;
        own_we   = m1_wb_we_i;
        own_sel  = m1_wb_sel_i;
        own_adr  = m1_wb_adr_i;
        own_wdat = m1_wb_wdat_i;
      end
      default: ;
    endcase
  end

  // Drive the shared bus and route responses back to the owner only
  always_comb begin
    s_wb_cyc_o    = own_cyc;
    s_wb_stb_o    = own_cyc & own_stb & ~full;
    s_wb_we_o     = own_we;
    s_wb_sel_o    = own_sel;
    s_wb_adr_o    = own_adr;
    s_wb_wdat_o   = own_wdat;
    m0_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m0_wb_rdat_o  = '0;
    m1_wb_stall_o = 1'b1;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    m1_wb_rdat_o  = '0;
    if (state_q == GNT0) begin
      m0_wb_stall_o = s_wb_stall_i | full;
      m0_wb_ack_o   = s_wb_ack_i & rsp_valid;
      m0_wb_err_o   = s_wb_err_i & rsp_valid;
      m0_wb_rdat_o  = s_wb_rdat_i;
    end else if (state_q == GNT1) begin
      m1_wb_stall_o = s_wb_stall_i | full;
      m1_wb_ack_o   = s_wb_ack_i & rsp_valid;
      m1_wb_err_o   = s_wb_err_i & rsp_valid;
      m1_wb_rdat_o  = s_wb_rdat_i;
    end
  end

  // Outstanding counter; cleared whenever nobody holds cyc (IDLE or abort)
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, rsp_valid})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: ;
    endcase
    if (!own_cyc) cnt_d = '0;
  end

  // Grant FSM: arbitrate only in IDLE, release when the owner drops cyc
  always_comb begin
    state_d = state_q;
`ifdef WB_DUAL_ARBITER_RR_EN
    last_m0_d = last_m0_q;
`endif
    case (state_q)
      IDLE: begin
        // arb_en_q holds off the first grant until one edge after reset release
        if (arb_en_q) begin
`ifdef WB_DUAL_ARBITER_RR_EN
          if (m0_wb_cyc_i && m1_wb_cyc_i) state_d = last_m0_q ? GNT1 : GNT0;
          else if (m1_wb_cyc_i)           state_d = GNT1;
          else if (m0_wb_cyc_i)           state_d = GNT0;
`else
          if (m1_wb_cyc_i)      state_d = GNT1;
          else if (m0_wb_cyc_i) state_d = GNT0;
`endif
        end
      end
      GNT0:    if (!m0_wb_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef WB_DUAL_ARBITER_RR_EN
    if (state_q == IDLE && state_d == GNT0) last_m0_d = 1'b1;
    if (state_q == IDLE && state_d == GNT1) last_m0_d = 1'b0;
`endif
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      arb_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arb_en_q <= 1'b1;
    end
  end

`ifdef WB_DUAL_ARBITER_RR_EN
  // Last-grant register for round-robin tie breaking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_m0_q <= 1'b0;
    else        last_m0_q <= last_m0_d;
  end
`endif

endmodule

// File: tb/tb_wb_dual_arbiter.sv
// Directed bench for wb_dual_arbiter (default parameters). Expected addresses and read
// data go through a scoreboard queue; everything else is checked against constants.
module tb_wb_dual_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_adr = '0, m0_wdat = '0;
  logic [31:0] m0_rdat;
  logic        m0_ack, m0_err, m0_stall;

  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_adr = '0, m1_wdat = '0;
  logic [31:0] m1_rdat;
  logic        m1_ack, m1_err, m1_stall;

  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [31:0] s_rdat = '0;
  logic        s_ack = 0, s_err = 0, s_stall = 0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_dual_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_wb_cyc_i  (m0_cyc),
    .m0_wb_stb_i  (m0_stb),
    .m0_wb_we_i   (m0_we),
    .m0_wb_sel_i  (m0_sel),
    .m0_wb_adr_i  (m0_adr),
    .m0_wb_wdat_i (m0_wdat),
    .m0_wb_rdat_o (m0_rdat),
    .m0_wb_ack_o  (m0_ack),
    .m0_wb_err_o  (m0_err),
    .m0_wb_stall_o(m0_stall),
    .m1_wb_cyc_i  (m1_cyc),
    .m1_wb_stb_i  (m1_stb),
    .m1_wb_we_i   (m1_we),
    .m1_wb_sel_i  (m1_sel),
    .m1_wb_adr_i  (m1_adr),
    .m1_wb_wdat_i (m1_wdat),
    .m1_wb_rdat_o (m1_rdat),
    .m1_wb_ack_o  (m1_ack),
    .m1_wb_err_o  (m1_err),
    .m1_wb_stall_o(m1_stall),
    .s_wb_cyc_o   (s_cyc),
    .s_wb_stb_o   (s_stb),
    .s_wb_we_o    (s_we),
    .s_wb_sel_o   (s_sel),
    .s_wb_adr_o   (s_adr),
    .s_wb_wdat_o  (s_wdat),
    .s_wb_rdat_i  (s_rdat),
    .s_wb_ack_i   (s_ack),
    .s_wb_err_i   (s_err),
    .s_wb_stall_i (s_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_pop(input string tag, input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, {32'h0, exp_q.pop_front()});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset: outputs quiet even with requests and a stray ack present
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #3;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_m1_ack", m1_ack, 0);
    tick(); tick();
    m1_stb = 0; s_ack = 0;
    rst_n = 1;
    settle();
    chk("rel_idle", s_cyc, 0);
    tick();
    chk("first_edge_no_grant", s_cyc, 0);
    tick();
    chk("second_edge_grant", s_cyc, 1);
    chk("m0_nonowner_stall", m0_stall, 1);
    m1_cyc = 0;
    tick();
    chk("idle_after_drop", m1_stall, 1);

    // m0 single read
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000_0010;
    exp_q.push_back(32'h1000_0010);
    settle();
    chk("m0_wait_in_idle", m0_stall, 1);
    tick();
    chk("m0_grant_cyc", s_cyc, 1);
    chk_pop("m0_adr", s_adr);
    chk("m0_owner_stall", m0_stall, 0);
    chk("m0_we", s_we, 0);
    tick();
    m0_stb = 0; s_ack = 1; s_rdat = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    settle();
    chk("m0_ack", m0_ack, 1);
    chk_pop("m0_rdat", m0_rdat);
    chk("m1_no_ack", m1_ack, 0);
    chk("m1_rdat_zero", m1_rdat, 0);
    tick();
    s_ack = 0; s_rdat = '0; m0_cyc = 0;
    tick();
    chk("m0_idle_after", m0_stall, 1);

    // Contention after a fresh reset
    rst_n = 0;
    settle();
    rst_n = 1;
    tick(); tick();
    m0_cyc = 1; m0_adr = 32'h100;
    m1_cyc = 1; m1_adr = 32'h200;
`ifdef WB_DUAL_ARBITER_RR_EN
    exp_q.push_back(32'h100);
`else
    exp_q.push_back(32'h200);
`endif
    tick();
    chk_pop("cont1_adr", s_adr);
`ifdef WB_DUAL_ARBITER_RR_EN
    chk("cont1_loser_stall", m1_stall, 1);
`else
    chk("cont1_loser_stall", m0_stall, 1);
`endif
    m0_cyc = 0; m1_cyc = 0;
    tick();
    chk("cont_idle_m0", m0_stall, 1);
    chk("cont_idle_m1", m1_stall, 1);
    m0_cyc = 1; m1_cyc = 1;
    exp_q.push_back(32'h200);
    tick();
    chk_pop("cont2_adr", s_adr);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // m1 burst of 6 with acks withheld: only 4 accepted
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h40;
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("burst_stall_%0d", k), m1_stall, 0);
      exp_q.push_back(m1_adr);
      chk_pop($sformatf("burst_adr_%0d", k), s_adr);
      tick();
      m1_adr = m1_adr + 32'd4;
    end
    settle();
    chk("full_stall", m1_stall, 1);
    chk("full_stb_gated", s_stb, 0);
    s_ack = 1;
    settle();
    chk("full_ack_fwd", m1_ack, 1);
    chk("stall_during_ack", m1_stall, 1);
    tick();
    s_ack = 0;
    settle();
    chk("release_after_ack", m1_stall, 0);
    chk("fifth_stb", s_stb, 1);
    tick();
    m1_adr = m1_adr + 32'd4;
    settle();
    chk("refull_stall", m1_stall, 1);
    s_err = 1;
    settle();
    chk("err_fwd", m1_err, 1);
    tick();
    s_err = 0;
    settle();
    chk("sixth_accept", m1_stall, 0);
    tick();
    m1_stb = 0;
    // drain 4 -> 2
    s_ack = 1;
    tick(); tick();
    // accept and ack together at count 2
    m1_stb = 1;
    settle();
    chk("simul_nostall", m1_stall, 0);
    chk("simul_ack", m1_ack, 1);
    tick();
    s_ack = 0;
    settle();
    chk("cnt2_nostall", m1_stall, 0);
    tick();
    chk("cnt3_nostall", m1_stall, 0);
    tick();
    chk("cnt4_full", m1_stall, 1);
    m1_stb = 0; m1_cyc = 0;
    tick();

    // m0 write aborts with 2 outstanding; m1 waiting
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hA;
    m0_adr = 32'h2000; m0_wdat = 32'hDEAD_BEEF;
    tick();
    m1_cyc = 1; m1_adr = 32'h3000;
    settle();
    chk("wr_we", s_we, 1);
    chk("wr_sel", s_sel, 4'hA);
    chk("wr_wdat", s_wdat, 32'hDEAD_BEEF);
    chk("pending_m1_stall", m1_stall, 1);
    tick(); tick();
    m0_stb = 0; m0_cyc = 0; m0_we = 0;
    tick();
    s_ack = 1;
    settle();
    chk("late_ack_m0", m0_ack, 0);
    chk("late_ack_m1", m1_ack, 0);
    chk("idle_gap", s_cyc, 0);
    tick();
    exp_q.push_back(32'h3000);
    chk("m1_after_gap", s_cyc, 1);
    chk_pop("m1_gap_adr", s_adr);
    chk("discard_cnt0", m1_ack, 0);
    s_ack = 0;

    // Async reset in GNT1 with 3 outstanding
    m1_stb = 1;
    tick(); tick(); tick();
    m1_stb = 0;
    settle();
    chk("pre_rst_cyc", s_cyc, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_cyc", s_cyc, 0);
    chk("async_rst_stall", m1_stall, 1);
    tick();
    rst_n = 1; m1_stb = 1;
    settle();
    chk("post_rst_idle0", s_cyc, 0);
    tick();
    chk("post_rst_idle1", s_cyc, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_rst_stall_%0d", k), m1_stall, 0);
      tick();
    end
    chk("post_rst_full", m1_stall, 1);
    m1_stb = 0; m1_cyc = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_dual_arbiter.md
WB_DUAL_ARBITER -- requirements
Module: wb_dual_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unacknowledged transfers per grant, range 1..15.
REQ-002 Parameter ADR_WIDTH, default 32: address width carried through.
REQ-003 Parameter DAT_WIDTH, default 32: data width carried through; SEL width is DAT_WIDTH/8.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port m0_wb, wb_if.slave, bundle: instruction-side Wishbone B4 pipelined master, lower fixed priority.
REQ-007 Port m1_wb, wb_if.slave, bundle: data-side Wishbone B4 pipelined master, higher fixed priority.
REQ-008 Port s_wb, wb_if.master, bundle: single shared downstream Wishbone B4 pipelined bus.

Function
REQ-009 FSM states: IDLE, GNT0, GNT1; grant is registered, so an accepted request is driven onto s_wb one cycle after cyc is seen in IDLE.
REQ-010 IDLE: m1 cyc -> GNT1; else m0 cyc -> GNT0; neither -> stay in IDLE.
REQ-011 In GNTx, owner's cyc, stb, we, sel, adr, dat_o pass combinationally to s_wb; owner receives s_wb ack, err, stall, dat_i.
REQ-012 Non-owner sees stall=1, ack=0, err=0, dat_i=0.
REQ-013 s_wb cyc/stb = 0 in IDLE; dat_o/adr/sel/we = 0 in IDLE.
REQ-014 Outstanding counter, width clog2(MAX_OUTSTANDING+1): +1 on s_wb stb&!stall; -1 on ack|err; both in the same cycle -> unchanged.
REQ-015 When counter == MAX_OUTSTANDING, owner sees stall=1 and s_wb stb is forced 0, regardless of s_wb stall.
REQ-016 An ack/err arriving while the counter is 0 is discarded and not forwarded to the owner; counter stays 0.
REQ-017 Owner deasserts cyc -> next state IDLE and counter cleared, even with outstanding > 0 (Wishbone abort); late ack/err falls under REQ-016.
REQ-018 Grant never changes while owner cyc=1; no preemption.
REQ-019 IDLE is visited for at least one cycle between any two grants.

Reset
REQ-020 rst_n low -> state IDLE, counter 0, last-grant register 0, asynchronously and in any state.
REQ-021 During reset: s_wb cyc/stb = 0; both masters see stall=1, ack=0, err=0.
REQ-022 First grant occurs no earlier than the second rising edge after rst_n deasserts.

Configuration
REQ-023 Macro WB_DUAL_ARBITER_RR_EN defined: IDLE arbitration with both cyc high grants the master not granted most recently (last-grant register, reset value selects m0 first).
REQ-024 Macro undefined: fixed priority per REQ-010; last-grant register absent.

Structure
REQ-025 Shared package wb_arb_pkg holds the state enum (IDLE, GNT0, GNT1) and a function computing the counter width.
REQ-026 No sub-module; single module, 120-250 lines.

Verification
REQ-027 m0 single read, m1 idle -> GNT0 one cycle after cyc; s_wb adr matches m0 adr; ack forwarded to m0 only; IDLE after cyc drops.
REQ-028 m0 and m1 assert cyc in the same cycle -> without macro, m1 granted; with macro, m0 first, then m1 on next contention.
REQ-029 m1 issues 6 back-to-back stb, MAX_OUTSTANDING=4, slave acks withheld -> 4 accepted, m1 stall=1 from the 4th acceptance; stall releases after the first ack.
REQ-030 Simultaneous acceptance and ack at counter 2 -> counter stays 2; no stall.
REQ-031 m0 owns bus with 2 outstanding and drops cyc; slave acks 1 cycle later -> ack not forwarded; pending m1 granted after one IDLE cycle.
REQ-032 rst_n pulled low in GNT1 with 3 outstanding -> s_wb cyc=0 immediately (asynchronous); after release, counter=0 and state IDLE.
